seg_595_scan_ctrl: RTL and testbench

Six-digit dynamic-scan controller for the 74HC595-driven seven-segment display. It converts a packed 6-digit BCD value and a decimal-point mask into per-digit segment/select words, then serialises each word into the two cascaded 595s. It drives `ds`/`shcp`/`stcp`/`oe` and sequences one digit per scan slot. It sits between the value-producing logic and the display pins.

---
 rtl/seg_595_scan_ctrl_if.sv | 15 +
 rtl/seg_595_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_595_scan_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_595_scan_ctrl_if.sv
// Signal bundle between the value-producing logic and the 595 scan controller.
// The master drives the digit value, DP mask and enable. The controller (slave)
// drives the four 595 pins.
interface seg_595_scan_ctrl_if;
    logic [23:0] data;
    logic [5:0]  point;
    logic        seg_en;
    logic        ds;
    logic        shcp;
    logic        stcp;
    logic        oe;

    modport master (output data, point, seg_en, input ds, shcp, stcp, oe);
    modport slave  (input data, point, seg_en, output ds, shcp, stcp, oe);
endinterface

// File: rtl/seg_595_scan_ctrl.sv
// Six-digit dynamic-scan controller for two cascaded 74HC595s.
//
// Each scan slot lasts CNT_SCAN cycles and runs through these steps:
//   LOAD  : capture one 14-bit word {seg[7:0], sel[5:0]}.
//   SHIFT : shift the word out MSB first, 4 cycles per bit.
//   LATCH : pulse stcp for one cycle.
//   HOLD  : wait for the rest of the slot.
//
// All pin outputs come straight from flops, computed one cycle ahead from the
// next state and next count, so shcp/stcp never glitch.
module seg_595_scan_ctrl #(
    parameter int CNT_SCAN = 50_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    seg_595_scan_ctrl_if.slave    bus
);

    localparam int              CW        = $clog2(CNT_SCAN);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CNT_SCAN - 1);
    localparam logic [CW-1:0]   SHIFT_END = CW'(56);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      dig_q, dig_d;
    logic [13:0]     word_q, word_d;
    logic            ds_q, shcp_q, stcp_q, oe_q;
    logic            ds_d, shcp_d, stcp_d, oe_d;

    logic [5:0][3:0] nibs;
    logic [CW-1:0]   sh;
    logic [3:0]      bit_k;

    assign nibs = bus.data;

    // Common-anode, active-low segments: bit7 = DP, bits 6..0 = g..a.
    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    // Next-state, slot counter, digit index and the look-ahead of the pin values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        dig_d   = dig_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                dig_d = '0;
                if (bus.seg_en) state_d = LOAD;
            end
            LOAD: begin
                word_d = {seg_of(nibs[dig_q]) & {~bus.point[dig_q], 7'h7F},
                          ~(6'b000001 << dig_q)};
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q == SHIFT_END) state_d = LATCH;
            LATCH: state_d = HOLD;
            HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    dig_d   = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Losing enable aborts the frame wherever it is.
        if (state_q != IDLE && !bus.seg_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            dig_d   = '0;
        end

        // The shift phase starts at count 1. Bit k occupies counts 1+4k..4+4k,
        // and shcp is high in the upper half of each 4-cycle bit.
        sh     = cnt_d - 1'b1;
        bit_k  = 4'(sh >> 2);
        ds_d   = (state_d == SHIFT) ? word_d[4'd13 - bit_k] : 1'b0;
        shcp_d = (state_d == SHIFT) && sh[1];
        stcp_d = (state_d == LATCH);

        // oe drops once the first word has been latched, and rises again on idle.
        oe_d = oe_q;
        if (state_d == IDLE)       oe_d = 1'b1;
        else if (state_q == LATCH) oe_d = 1'b0;
    end

    // State and registered pin outputs; reset takes effect immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
            word_q  <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            word_q  <= word_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            oe_q    <= oe_d;
        end
    end

    assign bus.ds   = ds_q;
    assign bus.shcp = shcp_q;
    assign bus.stcp = stcp_q;
    assign bus.oe   = oe_q;

endmodule

// File: tb/tb_seg_595_scan_ctrl.sv
// Scoreboard bench for seg_595_scan_ctrl.
// The stimulus side pushes the word each frame should carry, computed from a
// lookup table and digit arithmetic. The pin monitor rebuilds words from ds at
// shcp rises, and pops and compares them on every stcp pulse.
module tb_seg_595_scan_ctrl;

    localparam int CNT = 100;
    localparam logic [7:0] SEG_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    seg_595_scan_ctrl_if bus ();

    seg_595_scan_ctrl #(.CNT_SCAN(CNT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int          checks = 0;
    int          fails  = 0;
    logic [13:0] exp_q [$];
    logic        mon_flush = 1'b1;   // discard monitor state, no pin checks
    logic        mon_idle  = 1'b0;   // discard monitor state and expect idle pins
    int          digit = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference word for digit i of value d with DP mask p.
    function automatic logic [13:0] model(input logic [23:0] d, input logic [5:0] p, input int i);
        logic [3:0] n;
        logic [7:0] seg;
        logic [5:0] sel;
        n   = 4'(d >> (4 * i));
        seg = SEG_TBL[n];
        if (p[i]) seg = seg & 8'h7F;
        sel = 6'h3F ^ 6'(1 << i);
        return {seg, sel};
    endfunction

    // Present one frame's inputs and wait exactly one scan slot.
    task automatic run_frame(input logic [23:0] d, input logic [5:0] p, input bit push);
        bus.data  = d;
        bus.point = p;
        if (push) exp_q.push_back(model(d, p, digit));
        digit = (digit + 1) % 6;
        repeat (CNT) @(posedge sys_clk);
        #1;
    endtask

    // Pin monitor: rebuilds each shifted word and checks it at every latch pulse.
    logic        m_prev_shcp;
    logic [13:0] m_acc;
    int          m_nb;
    bit          m_lit;
    int          m_last;
    int          m_cyc;
    initial begin
        m_prev_shcp = 1'b0;
        m_acc  = '0;
        m_nb   = 0;
        m_lit  = 1'b0;
        m_last = -1;
        m_cyc  = 0;
        forever begin
            @(negedge sys_clk);
            m_cyc++;
            if (mon_flush || mon_idle) begin
                if (mon_idle) check("idle_pins", {bus.stcp, bus.shcp, bus.oe}, 3'b001);
                m_prev_shcp = 1'b0;
                m_nb   = 0;
                m_lit  = 1'b0;
                m_last = -1;
                continue;
            end
            check("oe_level", bus.oe, !m_lit);
            if (bus.shcp && !m_prev_shcp) begin
                m_acc = {m_acc[12:0], bus.ds};
                m_nb++;
            end
            m_prev_shcp = bus.shcp;
            if (bus.stcp) begin
                check("bits_per_frame", m_nb, 14);
                check("stcp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("frame_word", m_acc, exp_q.pop_front());
                if (m_last >= 0) check("stcp_period", m_cyc - m_last, CNT);
                m_last = m_cyc;
                m_nb   = 0;
                m_lit  = 1'b1;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        bus.seg_en = 1'b0;
        bus.data   = '0;
        bus.point  = '0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge sys_clk);
            check("reset_pins", {bus.ds, bus.shcp, bus.stcp, bus.oe}, 4'b0001);
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        mon_flush = 1'b0;
        repeat (200) @(posedge sys_clk);
        #1;
        check("disabled_pins", {bus.ds, bus.shcp, bus.stcp, bus.oe}, 4'b0001);

        // Directed frames, then random frames.
        digit = 0;
        bus.seg_en = 1'b1;
        run_frame(24'h000001, 6'b000000, 1'b1);
        repeat (7) run_frame(24'h987654, 6'b000000, 1'b1);
        repeat (6) run_frame(24'hFA0000, 6'b100000, 1'b1);
        repeat (10) run_frame(24'($urandom), 6'($urandom), 1'b1);

        // Drop enable during bit 7 of a frame; that frame must never latch.
        bus.data  = 24'($urandom);
        bus.point = 6'($urandom);
        repeat (31) @(posedge sys_clk);
        #1;
        bus.seg_en = 1'b0;
        @(posedge sys_clk);
        #1;
        mon_idle = 1'b1;
        repeat (150) @(posedge sys_clk);
        #1;
        digit = 0;
        bus.seg_en = 1'b1;
        mon_idle = 1'b0;
        repeat (3) run_frame(24'($urandom), 6'($urandom), 1'b1);

        // Asynchronous reset pulse in the middle of a shift.
        bus.data = 24'h888888;
        repeat (20) @(posedge sys_clk);
        #1;
        mon_flush = 1'b1;
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_pins", {bus.ds, bus.shcp, bus.stcp, bus.oe}, 4'b0001);
        #1;
        sys_rst_n = 1'b1;
        mon_flush = 1'b0;
        digit = 0;
        repeat (7) run_frame(24'($urandom), 6'($urandom), 1'b1);

        check("frames_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
